tile_buffer: RTL and testbench
==============================

# tile_buffer

- Tile FIFO directly downstream of the `load_m` DRAM tile loader.
- Captures each `TILE_WIDTH`-bit tile at its one-cycle strobe and tags the final tile of a transfer.
- Presents tiles first-word-fall-through to the compute datapath over a valid/ready handshake.
- The loader cannot be stalled, so overflow is flagged as a sticky error rather than back-pressured.

## Interface

Parameters:

- `TILE_WIDTH`, 256: tile width in bits; must match the loader.
- `DEPTH`, 8: tile entries; power of two, ≥2.

Ports:

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous active-low reset; asserted when 0.
- `tile_in` input `TILE_WIDTH`: tile data from the loader; sampled only when `tile_valid`=1.
- `tile_valid` input 1: one-cycle tile strobe (loader `tile_out`).
- `load_done` input 1: loader completion level (loader `valid_out`).
- `clear` input 1: synchronous flush.
- `rd_data` output `TILE_WIDTH`: head tile.
- `rd_last` output 1: head tile is the final tile of its transfer.
- `rd_valid` output 1: head entry is valid.
- `rd_ready` input 1: consumer accepts the head entry.
- `count` output `$clog2(DEPTH)+1`: number of occupied entries.
- `full` output 1: `count` == `DEPTH`.
- `overflow` output 1: sticky; a tile was dropped.

## Operation

- Storage: `DEPTH` entries of {last, data}. Write and read pointers are `$clog2(DEPTH)+1` bits wide, with the MSB used as a wrap bit.
- Full and empty conditions:
  - empty when the pointers are equal;
  - full when the low bits are equal and the MSBs differ;
  - `count` = wr_ptr − rd_ptr, modulo 2^(`$clog2(DEPTH)`+1).
- Push: `tile_valid`=1 and (!`full` or pop in the same cycle). The write is {`tile_valid` & `load_done`, `tile_in`}; wr_ptr then increments. The loader raises `tile_out` and `valid_out` on the same edge for its final tile, so last = `load_done` sampled together with `tile_valid`. `load_done` without `tile_valid` is ignored.
- Pop: `rd_valid` & `rd_ready`; rd_ptr then increments.
- Simultaneous push and pop:
  - When full: both are performed; `count` stays at `DEPTH`; the new tile lands in the freed slot.
  - When empty: a push only. `rd_valid` is 0 in that cycle, so no pop is possible.
- Overflow: `tile_valid`=1 while `full` and no pop → the tile is discarded, pointers are unchanged, and `overflow` goes to 1 until `clear` or reset.
- `clear`:
  - Resets both pointers to 0 and `overflow` to 0; array contents are don't-care.
  - `clear` has priority over a push or pop in the same cycle; the push is dropped and does not set `overflow`.
- Control FSM (`fsm_state_t`):
  - States: EMPTY, ACTIVE, FULL.
  - EMPTY→ACTIVE on a push.
  - ACTIVE→FULL when a push without a pop makes count=`DEPTH`.
  - ACTIVE→EMPTY when a pop without a push makes count=0.
  - FULL→ACTIVE on a pop without a push.
  - Any state → EMPTY on `clear`.
  - `full` and `rd_valid` decode from the state; they must agree with `count` at all times.

## Timing

- Reset values (asynchronous, when `rst`=0):
  - pointers 0, state EMPTY;
  - `rd_valid` 0, `rd_last` 0, `count` 0, `full` 0, `overflow` 0, `rd_data` 0.
- Array contents are not reset.
- Write-to-read latency is 1 cycle. A tile strobed in cycle N appears on `rd_data` with `rd_valid`=1 in cycle N+1 when the FIFO was empty.
- `rd_data` and `rd_last` come combinationally from the registered rd_ptr. They stay stable while `rd_valid`=1 and `rd_ready`=0.
- A pop in cycle N presents the next entry in cycle N+1.
- `count`, `full` and `overflow` are registered and update on the edge after the event.
- Ordering: tiles leave in strict arrival order. Pointer wrap at `DEPTH` must not reorder or corrupt entries.
- Reset asserted mid-stream: all state is lost immediately. No partial output is allowed after deassertion.

## Structure

- Package `tile_pkg` holds:
  - `TILE_WIDTH_DEF`=256;
  - `tile_entry_t` (packed struct {logic last; logic [TILE_WIDTH_DEF-1:0] data});
  - `fsm_state_t`.
- The module uses parameterised widths, not the package constant, for the data path.
- Single module with no sub-module. The storage array is inferred as registers.

## Test plan

- Single-tile load with `DEPTH`=8:
  - stimulus: `tile_valid`+`load_done` together with `tile_in`=0xA5…A5;
  - required: next cycle `rd_valid`=1, `rd_last`=1, `count`=1; a pop with `rd_ready`=1 returns the FIFO to empty.
- Four-tile load with `rd_ready`=0:
  - stimulus: strobes 3 cycles apart with data 1, 2, 3, 4; `load_done` only on the 4th;
  - required: `count`=4; pops return 1, 2, 3, 4 with `rd_last` only on 4.
- Overflow:
  - stimulus: 9 strobes with `rd_ready`=0;
  - required: `full`=1 after the 8th; the 9th is dropped and `overflow`=1; pops return tiles 1..8; `clear` zeroes `overflow` and `count`.
- Push and pop while full: `count` stays 8; the ninth tile is read after tile 8; `overflow` stays 0.
- Wrap-around: 20 tiles streamed with `rd_ready` toggling randomly; all 20 arrive in order and `count` never exceeds 8.
- Reset mid-stream:
  - stimulus: `rst`=0 asserted with 3 entries stored;
  - required: `rd_valid`=0 and `count`=0 asynchronously; after release, a fresh tile is read correctly.

Source files
------------

// File: rtl/tile_buffer_pkg.sv
// tile_buffer shared types: default tile width, entry layout, FSM states.
// Imported by the tile_buffer interface and top module.
package tile_pkg;

  localparam int TILE_WIDTH_DEF = 256;

  typedef struct packed {
    logic                      last;
    logic [TILE_WIDTH_DEF-1:0] data;
  } tile_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } fsm_state_t;

endpackage

// File: rtl/tile_buffer_if.sv
// Read-side valid/ready stream of the tile FIFO.
// master: drives rd_data/rd_last/rd_valid, samples rd_ready.
interface tile_buffer_if
  import tile_pkg::*;
#(
  parameter int TILE_WIDTH = TILE_WIDTH_DEF
) ();

  logic [TILE_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (
    output rd_data,
    output rd_last,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_last,
    input  rd_valid,
    output rd_ready
  );

endinterface

// File: rtl/tile_buffer.sv
// Tile FIFO after the DRAM loader: FWFT read, sticky overflow, tags last tile.
// Ports: clk, rst (async, low), tile_in/tile_valid/load_done, clear, rd (if), count/full/overflow.
module tile_buffer
  import tile_pkg::*;
#(
  parameter int TILE_WIDTH = TILE_WIDTH_DEF,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TILE_WIDTH-1:0]   tile_in,
  input  logic                    tile_valid,
  input  logic                    load_done,
  input  logic                    clear,
  tile_buffer_if.master           rd,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_TOP = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [TILE_WIDTH:0] mem [DEPTH];
  logic [TILE_WIDTH:0] head;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  fsm_state_t state;
  fsm_state_t nxt;

  logic push;
  logic pop;
  logic drop;

  // clear wins over everything in its cycle, so it gates both sides
  assign pop  = rd.rd_valid & rd.rd_ready & ~clear;
  assign push = tile_valid & (~full | pop) & ~clear;
  assign drop = tile_valid & full & ~pop & ~clear;

  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {tile_valid & load_done, tile_in};
    end
  end

  // gate the head so unwritten slots never leak onto the bus
  assign head        = mem[rd_ptr[AW-1:0]];
  assign rd.rd_data  = rd.rd_valid ? head[TILE_WIDTH-1:0] : '0;
  assign rd.rd_last  = rd.rd_valid & head[TILE_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_ONE;
      if (pop)  rd_ptr <= rd_ptr + CNT_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    if (clear) begin
      nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) nxt = ACTIVE;
        end
        ACTIVE: begin
          if (push && !pop && count == CNT_TOP) begin
            nxt = FULL;
          end else if (pop && !push && count == CNT_ONE) begin
            nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop && !push) nxt = ACTIVE;
        end
        default: nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    full        = 1'b0;
    rd.rd_valid = 1'b0;
    unique case (state)
      EMPTY: begin
      end
      ACTIVE: begin
        rd.rd_valid = 1'b1;
      end
      FULL: begin
        rd.rd_valid = 1'b1;
        full        = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_tile_buffer.sv
// Self-checking bench for tile_buffer: vector table plus hand sequences.
// Covers FWFT latency, last tagging, overflow, full push+pop, wrap, reset.
module tb_tile_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] tile_in = '0;
  logic         tile_valid = 1'b0;
  logic         load_done = 1'b0;
  logic         clear = 1'b0;
  logic [3:0]   count;
  logic         full;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  tile_buffer_if #(.TILE_WIDTH(256)) rd_if ();

  tile_buffer #(
    .TILE_WIDTH(256),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tile_in(tile_in),
    .tile_valid(tile_valid),
    .load_done(load_done),
    .clear(clear),
    .rd(rd_if),
    .count(count),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic        ld;
    logic        clr;
    logic        rdy;
    logic [31:0] d;
    logic        ev;
    logic        el;
    logic [3:0]  ec;
    logic        ef;
    logic        eo;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [255:0] t(input logic [31:0] d);
    return {8{d}};
  endfunction

  function automatic vec_t mk(
    input logic tv, ld, clr, rdy,
    input logic [31:0] d,
    input logic ev, el,
    input logic [3:0] ec,
    input logic ef, eo,
    input logic [31:0] ed
  );
    vec_t v;
    v.tv = tv; v.ld = ld; v.clr = clr; v.rdy = rdy; v.d = d;
    v.ev = ev; v.el = el; v.ec = ec; v.ef = ef; v.eo = eo; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tile_valid = 1'b0;
    load_done  = 1'b0;
    clear      = 1'b0;
    rd_if.rd_ready = 1'b0;
  endtask

  logic [31:0] q[$];
  int sent;
  int got;
  logic tv_r;
  logic rdy_r;
  logic pop_m;
  logic [31:0] exp_order [8];

  initial begin
    rd_if.rd_ready = 1'b0;

    vecs[0]  = mk(1,1,0,0,32'hA5A5A5A5, 1,1,1,0,0,32'hA5A5A5A5);
    vecs[1]  = mk(0,0,0,1,0,            0,0,0,0,0,0);
    vecs[2]  = mk(1,0,0,0,1,            1,0,1,0,0,1);
    vecs[3]  = mk(0,0,0,0,0,            1,0,1,0,0,1);
    vecs[4]  = mk(0,0,0,0,0,            1,0,1,0,0,1);
    vecs[5]  = mk(1,0,0,0,2,            1,0,2,0,0,1);
    vecs[6]  = mk(0,0,0,0,0,            1,0,2,0,0,1);
    vecs[7]  = mk(0,0,0,0,0,            1,0,2,0,0,1);
    vecs[8]  = mk(1,0,0,0,3,            1,0,3,0,0,1);
    vecs[9]  = mk(0,0,0,0,0,            1,0,3,0,0,1);
    vecs[10] = mk(0,0,0,0,0,            1,0,3,0,0,1);
    vecs[11] = mk(1,1,0,0,4,            1,0,4,0,0,1);
    vecs[12] = mk(0,0,0,1,0,            1,0,3,0,0,2);
    vecs[13] = mk(0,0,0,1,0,            1,0,2,0,0,3);
    vecs[14] = mk(0,0,0,1,0,            1,1,1,0,0,4);
    vecs[15] = mk(0,0,0,1,0,            0,0,0,0,0,0);
    vecs[16] = mk(0,1,0,0,0,            0,0,0,0,0,0);
    vecs[17] = mk(1,0,0,0,7,            1,0,1,0,0,7);
    vecs[18] = mk(1,0,1,0,8,            0,0,0,0,0,0);

    tick();
    chk("rst_valid", 256'(rd_if.rd_valid), 256'(0));
    chk("rst_last",  256'(rd_if.rd_last),  256'(0));
    chk("rst_count", 256'(count),          256'(0));
    chk("rst_full",  256'(full),           256'(0));
    chk("rst_ovf",   256'(overflow),       256'(0));
    chk("rst_data",  rd_if.rd_data,        256'(0));
    rst = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      tile_valid     = vecs[i].tv;
      load_done      = vecs[i].ld;
      clear          = vecs[i].clr;
      rd_if.rd_ready = vecs[i].rdy;
      tile_in        = t(vecs[i].d);
      tick();
      chk($sformatf("v%0d_valid", i), 256'(rd_if.rd_valid), 256'(vecs[i].ev));
      chk($sformatf("v%0d_last", i),  256'(rd_if.rd_last),  256'(vecs[i].el));
      chk($sformatf("v%0d_count", i), 256'(count),          256'(vecs[i].ec));
      chk($sformatf("v%0d_full", i),  256'(full),           256'(vecs[i].ef));
      chk($sformatf("v%0d_ovf", i),   256'(overflow),       256'(vecs[i].eo));
      chk($sformatf("v%0d_data", i),  rd_if.rd_data,        t(vecs[i].ed));
    end
    idle();

    // overflow: ninth strobe into a full FIFO is dropped
    for (int i = 1; i <= 9; i++) begin
      tile_valid = 1'b1;
      tile_in    = t(32'(i));
      tick();
      tile_valid = 1'b0;
      if (i == 8) begin
        chk("ovf_full8",  256'(full),     256'(1));
        chk("ovf_cnt8",   256'(count),    256'(8));
        chk("ovf_flag8",  256'(overflow), 256'(0));
      end
    end
    chk("ovf_flag9", 256'(overflow), 256'(1));
    chk("ovf_cnt9",  256'(count),    256'(8));
    chk("ovf_full9", 256'(full),     256'(1));
    rd_if.rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), rd_if.rd_data, t(32'(i)));
      tick();
    end
    rd_if.rd_ready = 1'b0;
    chk("ovf_drained", 256'(rd_if.rd_valid), 256'(0));
    chk("ovf_sticky",  256'(overflow),       256'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf",   256'(overflow), 256'(0));
    chk("clr_count", 256'(count),    256'(0));

    // push and pop in the same cycle while full
    for (int i = 1; i <= 8; i++) begin
      tile_valid = 1'b1;
      tile_in    = t(32'h10 + 32'(i));
      tick();
    end
    chk("pp_full", 256'(full), 256'(1));
    tile_in        = t(32'h99);
    rd_if.rd_ready = 1'b1;
    tick();
    tile_valid     = 1'b0;
    rd_if.rd_ready = 1'b0;
    chk("pp_count", 256'(count),    256'(8));
    chk("pp_fullk", 256'(full),     256'(1));
    chk("pp_ovf",   256'(overflow), 256'(0));
    for (int i = 0; i < 7; i++) exp_order[i] = 32'h12 + 32'(i);
    exp_order[7] = 32'h99;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_pop%0d", i), rd_if.rd_data, t(exp_order[i]));
      tick();
    end
    rd_if.rd_ready = 1'b0;
    chk("pp_empty", 256'(rd_if.rd_valid), 256'(0));
    chk("pp_ovf2",  256'(overflow),       256'(0));

    // wrap-around streaming against a queue model
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      chk("wr_valid", 256'(rd_if.rd_valid), 256'(q.size() != 0));
      if (q.size() != 0) begin
        chk("wr_data", rd_if.rd_data, t(q[0]));
        chk("wr_last", 256'(rd_if.rd_last), 256'(q[0] == 32'h113));
      end
      tv_r  = (sent < 20) && (q.size() < 8) && ($urandom_range(0, 3) != 0);
      rdy_r = 1'($urandom_range(0, 1));
      tile_valid     = tv_r;
      load_done      = tv_r && (sent == 19);
      tile_in        = t(32'h100 + 32'(sent));
      rd_if.rd_ready = rdy_r;
      pop_m = (q.size() != 0) && rdy_r;
      tick();
      if (pop_m) begin
        void'(q.pop_front());
        got++;
      end
      if (tv_r) begin
        q.push_back(32'h100 + 32'(sent));
        sent++;
      end
      chk("wr_count", 256'(count), 256'(q.size()));
      chk("wr_le8",   256'(count <= 4'd8), 256'(1));
    end
    idle();
    chk("wr_all20", 256'(got), 256'(20));

    // reset asserted mid-stream
    for (int i = 0; i < 3; i++) begin
      tile_valid = 1'b1;
      tile_in    = t(32'h31 + 32'(i));
      tick();
    end
    tile_valid = 1'b0;
    chk("mr_pre", 256'(count), 256'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", 256'(rd_if.rd_valid), 256'(0));
    chk("mr_count", 256'(count),          256'(0));
    chk("mr_data",  rd_if.rd_data,        256'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("mr_post", 256'(rd_if.rd_valid), 256'(0));
    tile_valid = 1'b1;
    load_done  = 1'b1;
    tile_in    = t(32'hBEEF);
    tick();
    idle();
    chk("mr_fvalid", 256'(rd_if.rd_valid), 256'(1));
    chk("mr_flast",  256'(rd_if.rd_last),  256'(1));
    chk("mr_fdata",  rd_if.rd_data,        t(32'hBEEF));
    chk("mr_fcount", 256'(count),          256'(1));
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    chk("mr_done", 256'(rd_if.rd_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
